// File: rtl/mwc_pkg.sv
// Shared types and constants for the data-memory write checker.
// Holds the FSM state encoding, failure codes and the table index-width helper.
package mwc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ADDR    = 2'd1;
    localparam logic [1:0] FC_DATA    = 2'd2;
    localparam logic [1:0] FC_TIMEOUT = 2'd3;

    // A one-entry table still needs a one-bit index.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mwc_table.sv
// Expected-store register file: one synchronous write port and every entry
// exposed in parallel so the unordered matcher can scan them all in one cycle.
module mwc_table
    import mwc_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [idx_w(DEPTH)-1:0]        widx,
    input  logic [AW-1:0]                  waddr,
    input  logic [DW-1:0]                  wdata,
    output logic [DEPTH-1:0][AW-1:0]       rd_addr,
    output logic [DEPTH-1:0][DW-1:0]       rd_data
);

    // Contents are deliberately not reset; they are meaningful only after loading.
    always_ff @(posedge clk) begin
        if (we) begin
            rd_addr[widx] <= waddr;
            rd_data[widx] <= wdata;
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Self-checking monitor for the data-memory write bus: compares observed stores
// against a loaded table and holds a sticky pass/fail verdict until cleared.
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int          AW       = 32,
    parameter int          DW       = 32,
    parameter int          DEPTH    = 8,
    parameter bit          IGN_EN   = 1'b1,
    parameter logic [AW-1:0] IGN_ADDR = 80,
    parameter bit          ORDERED  = 1'b1,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      memwrite,
    input  logic [AW-1:0]             dataadr,
    input  logic [DW-1:0]             writedata,
    input  logic                      ld_en,
    input  logic [idx_w(DEPTH)-1:0]   ld_idx,
    input  logic [AW-1:0]             ld_addr,
    input  logic [DW-1:0]             ld_data,
    input  logic [idx_w(DEPTH):0]     num_exp,
    input  logic                      start,
    input  logic                      clr,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      fail,
    output logic [1:0]                fail_code,
    output logic [AW-1:0]             err_addr,
    output logic [DW-1:0]             err_data,
    output logic [idx_w(DEPTH):0]     match_cnt,
    output logic [31:0]               cycle_cnt
);

    localparam int          IW      = idx_w(DEPTH);
    localparam int          CW      = IW + 1;
    localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t                  state, state_n;
    logic [CW-1:0]           num_lat, num_n;
    logic [CW-1:0]           match_n;
    logic [31:0]             cycle_n;
    logic [1:0]              fc_n;
    logic [AW-1:0]           ea_n;
    logic [DW-1:0]           ed_n;
    logic [DEPTH-1:0]        hit, hit_n;

    logic [DEPTH-1:0][AW-1:0] tbl_addr;
    logic [DEPTH-1:0][DW-1:0] tbl_data;

    logic                    ev;
    logic                    ord_match, ord_addr_eq;
    logic                    un_found, un_addr_eq;
    logic [IW-1:0]           un_idx;
    logic                    ev_match, ev_addr_eq;

    mwc_table #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_table (
        .clk     (clk),
        .we      (reset && ld_en && (state == IDLE)),
        .widx    (ld_idx),
        .waddr   (ld_addr),
        .wdata   (ld_data),
        .rd_addr (tbl_addr),
        .rd_data (tbl_data)
    );

    // While running, match_cnt < num_lat <= DEPTH, so its low bits index the table.
    always_comb begin
        ev          = memwrite && !(IGN_EN && (dataadr == IGN_ADDR));
        ord_addr_eq = (tbl_addr[match_cnt[IW-1:0]] == dataadr);
        ord_match   = ord_addr_eq && (tbl_data[match_cnt[IW-1:0]] == writedata);
    end

    // Descending scan so the lowest matching unhit entry is the one kept.
    always_comb begin
        un_found   = 1'b0;
        un_addr_eq = 1'b0;
        un_idx     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CW'(i) < num_lat) && !hit[i] && (tbl_addr[i] == dataadr)) begin
                un_addr_eq = 1'b1;
                if (tbl_data[i] == writedata) begin
                    un_found = 1'b1;
                    un_idx   = IW'(i);
                end
            end
        end
        ev_match   = ORDERED ? ord_match   : un_found;
        ev_addr_eq = ORDERED ? ord_addr_eq : un_addr_eq;
    end

    always_comb begin
        state_n = state;
        num_n   = num_lat;
        match_n = match_cnt;
        cycle_n = cycle_cnt;
        fc_n    = fail_code;
        ea_n    = err_addr;
        ed_n    = err_data;
        hit_n   = hit;
        case (state)
            IDLE: begin
                if (start && (num_exp != '0) && (num_exp <= CW'(DEPTH))) begin
                    state_n = RUN;
                    num_n   = num_exp;
                    match_n = '0;
                    cycle_n = '0;
                    fc_n    = FC_NONE;
                    ea_n    = '0;
                    ed_n    = '0;
                    hit_n   = '0;
                end
            end
            RUN: begin
                if (cycle_cnt != 32'hFFFF_FFFF) begin
                    cycle_n = cycle_cnt + 32'd1;
                end
                if (ev && ev_match) begin
                    match_n = match_cnt + CW'(1);
                    if (!ORDERED) begin
                        hit_n[un_idx] = 1'b1;
                    end
                    if ((match_cnt + CW'(1)) == num_lat) begin
                        state_n = PASS;
                    end
                end else if (ev) begin
                    state_n = FAIL;
                    fc_n    = ev_addr_eq ? FC_DATA : FC_ADDR;
                    ea_n    = dataadr;
                    ed_n    = writedata;
                end
                // A completing match or an offending write on this edge outranks the timeout.
                if ((TIMEOUT != 0) && (cycle_cnt == TO_LAST) && (state_n == RUN)) begin
                    state_n = FAIL;
                    fc_n    = FC_TIMEOUT;
                    ea_n    = '0;
                    ed_n    = '0;
                end
            end
            PASS, FAIL: begin
                if (clr) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            num_lat   <= '0;
            match_cnt <= '0;
            cycle_cnt <= '0;
            fail_code <= FC_NONE;
            err_addr  <= '0;
            err_data  <= '0;
            hit       <= '0;
        end else begin
            state     <= state_n;
            num_lat   <= num_n;
            match_cnt <= match_n;
            cycle_cnt <= cycle_n;
            fail_code <= fc_n;
            err_addr  <= ea_n;
            err_data  <= ed_n;
            hit       <= hit_n;
        end
    end

    assign busy = (state == RUN);
    assign pass = (state == PASS);
    assign fail = (state == FAIL);
    assign done = pass || fail;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: an ordered and an unordered instance share one
// stimulus stream; a store-list reference model predicts every output each cycle.
module tb_mem_write_checker;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int IW    = 3;
    localparam int CW    = 4;
    localparam int TO    = 20;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_PASS = 2;
    localparam int S_FAIL = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          memwrite = 1'b0;
    logic [AW-1:0] dataadr = '0;
    logic [DW-1:0] writedata = '0;
    logic          ld_en = 1'b0;
    logic [IW-1:0] ld_idx = '0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic [CW-1:0] num_exp = '0;
    logic          start = 1'b0;
    logic          clr = 1'b0;

    logic          busy [2];
    logic          done [2];
    logic          pass [2];
    logic          fail [2];
    logic [1:0]    fail_code [2];
    logic [AW-1:0] err_addr [2];
    logic [DW-1:0] err_data [2];
    logic [CW-1:0] match_cnt [2];
    logic [31:0]   cycle_cnt [2];

    int tests = 0;
    int fails = 0;

    // Reference model: per instance a verdict, the list of stores still owed and counters.
    int          mst  [2];
    int          mcnt [2];
    int          mnum [2];
    longint      mcyc [2];
    int          mfc  [2];
    logic [31:0] mea  [2];
    logic [31:0] med  [2];
    logic [31:0] ta   [2][DEPTH];
    logic [31:0] td   [2][DEPTH];
    bit          used [2][DEPTH];

    logic [31:0] gen_a [DEPTH];
    logic [31:0] gen_d [DEPTH];
    int          order [DEPTH];

    always #5 clk = ~clk;

    mem_write_checker #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .IGN_EN(1'b1), .IGN_ADDR(32'd80),
        .ORDERED(1'b1), .TIMEOUT(TO)
    ) u_ord (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .ld_en(ld_en), .ld_idx(ld_idx), .ld_addr(ld_addr),
        .ld_data(ld_data), .num_exp(num_exp), .start(start), .clr(clr),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail(fail[0]),
        .fail_code(fail_code[0]), .err_addr(err_addr[0]), .err_data(err_data[0]),
        .match_cnt(match_cnt[0]), .cycle_cnt(cycle_cnt[0])
    );

    mem_write_checker #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .IGN_EN(1'b1), .IGN_ADDR(32'd80),
        .ORDERED(1'b0), .TIMEOUT(TO)
    ) u_uno (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .ld_en(ld_en), .ld_idx(ld_idx), .ld_addr(ld_addr),
        .ld_data(ld_data), .num_exp(num_exp), .start(start), .clr(clr),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail(fail[1]),
        .fail_code(fail_code[1]), .err_addr(err_addr[1]), .err_data(err_data[1]),
        .match_cnt(match_cnt[1]), .cycle_cnt(cycle_cnt[1])
    );

    task automatic checkVal(input string tag, input int m, input logic [31:0] obs,
                            input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s[%0d] observed=%0d expected=%0d", tag, m, obs, exp);
        end
    endtask

    task automatic modelEdge();
        int  hit_idx;
        bit  addr_seen;
        bit  finished;
        for (int m = 0; m < 2; m++) begin
            hit_idx   = -1;
            addr_seen = 1'b0;
            finished  = 1'b0;
            if (!reset) begin
                mst[m] = S_IDLE; mcnt[m] = 0; mcyc[m] = 0; mfc[m] = 0;
                mea[m] = '0; med[m] = '0;
            end else if (mst[m] == S_IDLE) begin
                if (start && num_exp >= 1 && num_exp <= DEPTH) begin
                    mst[m] = S_RUN; mnum[m] = int'(num_exp); mcnt[m] = 0; mcyc[m] = 0;
                    mfc[m] = 0; mea[m] = '0; med[m] = '0;
                    for (int i = 0; i < DEPTH; i++) used[m][i] = 1'b0;
                end
                if (ld_en) begin
                    ta[m][ld_idx] = ld_addr;
                    td[m][ld_idx] = ld_data;
                end
            end else if (mst[m] == S_RUN) begin
                if (memwrite && dataadr != 32'd80) begin
                    if (m == 0) begin
                        if (ta[m][mcnt[m]] == dataadr && td[m][mcnt[m]] == writedata)
                            hit_idx = mcnt[m];
                        addr_seen = (ta[m][mcnt[m]] == dataadr);
                    end else begin
                        for (int i = 0; i < mnum[m]; i++) begin
                            if (!used[m][i] && ta[m][i] == dataadr) begin
                                addr_seen = 1'b1;
                                if (hit_idx < 0 && td[m][i] == writedata) hit_idx = i;
                            end
                        end
                    end
                    finished = 1'b1;
                    if (hit_idx >= 0) begin
                        used[m][hit_idx] = 1'b1;
                        mcnt[m]++;
                        if (mcnt[m] == mnum[m]) mst[m] = S_PASS;
                        else finished = 1'b0;
                    end else begin
                        mst[m] = S_FAIL;
                        mfc[m] = addr_seen ? 2 : 1;
                        mea[m] = dataadr;
                        med[m] = writedata;
                    end
                end
                if (!finished && mcyc[m] == TO - 1) begin
                    mst[m] = S_FAIL; mfc[m] = 3; mea[m] = '0; med[m] = '0;
                end
                if (mcyc[m] < 64'hFFFF_FFFF) mcyc[m]++;
            end else if (clr) begin
                mst[m] = S_IDLE;
            end
        end
    endtask

    task automatic checkOutput();
        for (int m = 0; m < 2; m++) begin
            checkVal("busy",      m, 32'(busy[m]),      32'(mst[m] == S_RUN));
            checkVal("done",      m, 32'(done[m]),      32'(mst[m] >= S_PASS));
            checkVal("pass",      m, 32'(pass[m]),      32'(mst[m] == S_PASS));
            checkVal("fail",      m, 32'(fail[m]),      32'(mst[m] == S_FAIL));
            checkVal("fail_code", m, 32'(fail_code[m]), 32'(mfc[m]));
            checkVal("err_addr",  m, err_addr[m],       mea[m]);
            checkVal("err_data",  m, err_data[m],       med[m]);
            checkVal("match_cnt", m, 32'(match_cnt[m]), 32'(mcnt[m]));
            checkVal("cycle_cnt", m, cycle_cnt[m],      mcyc[m][31:0]);
        end
    endtask

    // One clock: model the edge, check every output, then drop single-cycle strobes.
    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
        memwrite = 1'b0; ld_en = 1'b0; start = 1'b0; clr = 1'b0;
    endtask

    task automatic applyStimulus(input logic mw, input logic [31:0] a, input logic [31:0] d);
        memwrite = mw; dataadr = a; writedata = d;
        step();
    endtask

    task automatic loadEntry(input int idx, input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_idx = IW'(idx); ld_addr = a; ld_data = d;
        step();
    endtask

    task automatic startRun(input int n);
        start = 1'b1; num_exp = CW'(n);
        step();
    endtask

    task automatic doClr();
        clr = 1'b1;
        step();
    endtask

    task automatic doReset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        int n, j, sel, tmp;

        // Reset state
        doReset();
        for (int m = 0; m < 2; m++) begin
            checkVal("rst_busy",  m, 32'(busy[m]), 0);
            checkVal("rst_done",  m, 32'(done[m]), 0);
            checkVal("rst_match", m, 32'(match_cnt[m]), 0);
        end

        // Single store with an ignored scratch write in front of it
        loadEntry(0, 84, 34);
        startRun(1);
        applyStimulus(1, 80, 7);
        for (int m = 0; m < 2; m++) checkVal("s1_busy", m, 32'(busy[m]), 1);
        applyStimulus(1, 84, 34);
        for (int m = 0; m < 2; m++) begin
            checkVal("s1_pass",  m, 32'(pass[m]), 1);
            checkVal("s1_match", m, 32'(match_cnt[m]), 1);
            checkVal("s1_fc",    m, 32'(fail_code[m]), 0);
        end
        doClr();

        // Three-store table written out of order
        loadEntry(0, 60, 1);
        loadEntry(1, 64, 2);
        loadEntry(2, 68, 3);
        startRun(3);
        applyStimulus(1, 64, 2);
        checkVal("s2_fail",  0, 32'(fail[0]), 1);
        checkVal("s2_fc",    0, 32'(fail_code[0]), 1);
        checkVal("s2_eaddr", 0, err_addr[0], 64);
        checkVal("s2_edata", 0, err_data[0], 2);
        checkVal("s2_match", 0, 32'(match_cnt[0]), 0);
        checkVal("s3_match1", 1, 32'(match_cnt[1]), 1);
        applyStimulus(1, 68, 3);
        applyStimulus(1, 60, 1);
        checkVal("s3_pass",  1, 32'(pass[1]), 1);
        checkVal("s3_match", 1, 32'(match_cnt[1]), 3);
        doClr();
        startRun(3);
        applyStimulus(1, 60, 9);
        for (int m = 0; m < 2; m++) begin
            checkVal("s3_fc",    m, 32'(fail_code[m]), 2);
            checkVal("s3_edata", m, err_data[m], 9);
        end
        doClr();

        // Timeout, then a completing write on the timeout edge
        loadEntry(0, 84, 34);
        startRun(1);
        repeat (TO - 1) applyStimulus(0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            checkVal("s4_cyc",  m, cycle_cnt[m], TO - 1);
            checkVal("s4_busy", m, 32'(busy[m]), 1);
        end
        applyStimulus(0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            checkVal("s4_fail",  m, 32'(fail[m]), 1);
            checkVal("s4_fc",    m, 32'(fail_code[m]), 3);
            checkVal("s4_eaddr", m, err_addr[m], 0);
        end
        doClr();
        startRun(1);
        repeat (TO - 1) applyStimulus(0, 0, 0);
        applyStimulus(1, 84, 34);
        for (int m = 0; m < 2; m++) checkVal("s4_pass_wins", m, 32'(pass[m]), 1);
        doClr();

        // Reset mid-run, then replay the single-store run on the retained table
        loadEntry(1, 88, 5);
        startRun(2);
        applyStimulus(1, 84, 34);
        for (int m = 0; m < 2; m++) checkVal("s5_match", m, 32'(match_cnt[m]), 1);
        doReset();
        for (int m = 0; m < 2; m++) begin
            checkVal("s5_busy",  m, 32'(busy[m]), 0);
            checkVal("s5_done",  m, 32'(done[m]), 0);
            checkVal("s5_match0", m, 32'(match_cnt[m]), 0);
            checkVal("s5_cyc",   m, cycle_cnt[m], 0);
        end
        startRun(1);
        applyStimulus(1, 80, 7);
        applyStimulus(1, 84, 34);
        for (int m = 0; m < 2; m++) checkVal("s5_pass", m, 32'(pass[m]), 1);
        doClr();

        // Illegal num_exp, load attempt while running, clr back to idle
        startRun(0);
        for (int m = 0; m < 2; m++) checkVal("s6_n0_busy", m, 32'(busy[m]), 0);
        startRun(DEPTH + 1);
        for (int m = 0; m < 2; m++) checkVal("s6_n9_busy", m, 32'(busy[m]), 0);
        startRun(1);
        ld_en = 1'b1; ld_idx = '0; ld_addr = 99; ld_data = 99;
        step();
        applyStimulus(1, 84, 34);
        for (int m = 0; m < 2; m++) checkVal("s6_tbl_kept", m, 32'(pass[m]), 1);
        doClr();
        for (int m = 0; m < 2; m++) begin
            checkVal("s6_clr_done", m, 32'(done[m]), 0);
            checkVal("s6_clr_match", m, 32'(match_cnt[m]), 1);
        end

        // Randomized runs: mostly the right stores, with noise, shuffles and idle gaps
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                gen_a[i] = 32'(60 + 4 * $urandom_range(0, 7));
                gen_d[i] = 32'($urandom_range(0, 3));
                loadEntry(i, gen_a[i], gen_d[i]);
            end
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < DEPTH; i++) order[i] = i;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = n - 1; i > 0; i--) begin
                    sel = $urandom_range(0, i);
                    tmp = order[i]; order[i] = order[sel]; order[sel] = tmp;
                end
            end
            startRun(n);
            j = 0;
            for (int c = 0; c < TO + 4; c++) begin
                sel = $urandom_range(0, 9);
                if (sel < 2) applyStimulus(0, 0, 0);
                else if (sel == 2) applyStimulus(1, 80, 32'($urandom_range(0, 3)));
                else if (sel == 3)
                    applyStimulus(1, 32'(60 + 4 * $urandom_range(0, 7)), 32'($urandom_range(0, 3)));
                else if (j < n) begin
                    applyStimulus(1, gen_a[order[j]], gen_d[order[j]]);
                    j++;
                end else applyStimulus(0, 0, 0);
            end
            doClr();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
Synthesizable self-checking monitor for the processor data-memory write bus.
- Holds a loadable table of expected (address, data) stores.
- Watches memwrite/dataadr/writedata and declares pass or fail.
- Pass/fail is held until cleared, so the same checker works in simulation benches and on FPGA (LED/status readout).
- Generalises the fixed single-store check to DEPTH stores, ordered or unordered matching, one ignored scratch address and a timeout.

Parameters:
AW, 32, address width of dataadr
DW, 32, data width of writedata
DEPTH, 8, expected-store table entries (power of two, >=2)
IGN_EN, 1, 1 = writes to IGN_ADDR are ignored
IGN_ADDR, 80, scratch address excluded from checking when IGN_EN=1
ORDERED, 1, 1 = stores must occur in table order; 0 = any order
TIMEOUT, 1000, RUN cycles before fail; 0 disables the timeout

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
memwrite  in  1  data-memory write strobe
dataadr  in  AW  write address
writedata  in  DW  write data
ld_en  in  1  table load strobe (honoured in IDLE only)
ld_idx  in  $clog2(DEPTH)  table entry index
ld_addr  in  AW  expected address
ld_data  in  DW  expected data
num_exp  in  $clog2(DEPTH)+1  number of valid entries used by the run
start  in  1  begin checking (IDLE only)
clr  in  1  return from PASS/FAIL to IDLE
busy  out  1  high in RUN
done  out  1  high in PASS or FAIL
pass  out  1  high in PASS
fail  out  1  high in FAIL
fail_code  out  2  0 none, 1 unexpected address, 2 data mismatch, 3 timeout
err_addr  out  AW  dataadr of the failing write (0 on timeout)
err_data  out  DW  writedata of the failing write (0 on timeout)
match_cnt  out  $clog2(DEPTH)+1  expected stores matched so far
cycle_cnt  out  32  cycles spent in RUN, saturating

Behaviour:
- reset=0 at a clock edge: state goes to IDLE and every output is cleared to 0. The table RAM is not reset and is valid only after loading.
- Reset wins over every other input. Reset during RUN abandons the run with no pass or fail.
- FSM states: IDLE, RUN, PASS, FAIL.
- IDLE:
  - ld_en writes entry[ld_idx]. ld_en in any other state is ignored.
  - start with 1<=num_exp<=DEPTH: latch num_exp, clear match_cnt, cycle_cnt, fail_code, err_addr, err_data and the hit bitmap, then go to RUN.
  - start with num_exp outside that range is ignored and the state stays IDLE.
- RUN:
  - cycle_cnt increments every cycle, saturating at 2^32-1.
  - Each edge with memwrite=1 is one write event. If IGN_EN=1 and dataadr==IGN_ADDR, the event is discarded.
- ORDERED=1, comparing the event against entry[match_cnt]:
  - Address and data both equal: match_cnt+1.
  - Address equal, data different: FAIL, code 2.
  - Address different: FAIL, code 1.
- ORDERED=0:
  - The event matches if any unhit entry below num_exp has equal address and data. The lowest such index is chosen, its hit bit is set and match_cnt+1.
  - An unhit entry with equal address but different data gives FAIL, code 2.
  - Otherwise the event gives FAIL, code 1.
  - Duplicate table entries need one write each.
- The event that makes match_cnt reach num_exp moves the state to PASS.
- Timeout: TIMEOUT!=0 and cycle_cnt==TIMEOUT-1 with no completing event gives FAIL, code 3.
- Same edge as a completing match: PASS wins over timeout.
- On FAIL, err_addr and err_data capture the offending event.
- Latency: busy, done, pass, fail, fail_code and the err registers update on the clock edge that samples the event. They are visible the cycle after memwrite is presented.
- PASS and FAIL are sticky. Bus activity, start and ld_en are ignored. clr moves the state to IDLE. Outputs keep their values until the next start, except busy, done, pass and fail, which clear in IDLE.
- Widths: equality compares use the full AW/DW width, with no truncation.

Decomposition:
- Shared package mwc_pkg holds:
  - state enum (IDLE, RUN, PASS, FAIL);
  - fail_code constants (FC_NONE, FC_ADDR, FC_DATA, FC_TIMEOUT);
  - the index-width helper function.
- One sub-module, mwc_table: a DEPTH x (AW+DW) register file with synchronous write and DEPTH-wide parallel read. The parallel read serves the unordered matcher; the ordered matcher uses entry[match_cnt].
- The FSM, counters and matcher stay in the top module.

Test Plan:
1. Set ORDERED=1, IGN_EN=1. Load {84:34} with num_exp=1 and start. Write 80:7, then 84:34. Required: pass=1 the following cycle, match_cnt=1, fail_code=0.
2. Set ORDERED=1. Load {60:1, 64:2, 68:3}. Write 64:2 first. Required: fail=1, fail_code=1, err_addr=64, err_data=2, match_cnt=0.
3. Set ORDERED=0. Load the same table. Write 68:3, 60:1, 64:2. Required: pass=1, match_cnt=3. Re-run and write 60:9. Required: fail_code=2, err_data=9.
4. Set TIMEOUT=20. Load {84:34}, start, and drive no writes. Required: fail=1, fail_code=3 with cycle_cnt=19 at the transition. Also drive the matching write in cycle 19. Required: pass wins.
5. Drive reset=0 mid-RUN after one match. Required: IDLE with all outputs 0. A start without reloading the table reproduces the scenario 1 result.
6. Start with num_exp=0 and with num_exp=DEPTH+1. Required: remains IDLE with busy=0. Also: ld_en during RUN leaves the table unchanged, and clr in PASS returns to IDLE.
